aemb2_tsched: RTL
=================

Name: aemb2_tsched

Overview:
- Pipeline sequencer and hardware-thread scheduler for the AEMB2 core.
- Generates the global pipeline enable (dena) and thread phase (gpha) consumed by the integer unit and the rest of the pipeline.
- Stalls the pipeline on outstanding instruction-bus, data-bus or FSL transactions.
- Arbitrates external interrupt injection into thread 0; optionally aborts hung bus cycles.

Parameters:
- AEMB_HTX, 1, hardware threads enabled; 1 = gpha toggles per advance, 0 = gpha held 0.
- AEMB_TOW, 8, width of bus-timeout counter; timeout after 2^AEMB_TOW-1 stalled cycles.
- AEMB_RSC, 4, post-reset hold cycles with dena low (pipeline drain), 1..15.

Ports:
- gclk  in  1  core clock; all state on rising edge.
- grst  in  1  synchronous reset, active-low: grst=0 resets.
- iwb_stb  in  1  instruction fetch outstanding.
- iwb_ack  in  1  instruction fetch complete.
- dwb_stb  in  1  data access outstanding.
- dwb_ack  in  1  data access complete.
- fsl_stb  in  1  FSL access outstanding.
- fsl_ack  in  1  FSL access complete.
- sys_int  in  1  external interrupt, level-sensitive.
- msr_ie  in  1  MSR IE bit of the current thread.
- msr_bip  in  1  MSR BIP bit of the current thread.
- dena  out  1  pipeline advance enable.
- gpha  out  1  current thread phase.
- int_take  out  1  inject interrupt into the instruction in OF this cycle.
- berr  out  1  bus-timeout abort pulse.

Behaviour:
- pend = (iwb_stb&~iwb_ack) | (dwb_stb&~dwb_ack) | (fsl_stb&~fsl_ack), combinational.
- FSM states: HOLD, RUN, WAIT, ABRT.
- Reset (grst=0): state=HOLD, hold counter=AEMB_RSC-1, gpha=0, int_pend=0, timeout counter=0. Outputs dena=0, int_take=0, berr=0.
- HOLD: dena=0; counter decrements; at 0 go to RUN. grst=0 at any time returns to HOLD, including mid-WAIT or mid-ABRT.
- RUN:
  - dena = ~pend, combinational, zero-latency stall.
  - If pend, go to WAIT and clear the timeout counter.
- WAIT:
  - dena = ~pend, so a cycle with an ack advances immediately.
  - Timeout counter increments each pend cycle.
  - ~pend: go to RUN.
  - Counter reaches all-ones with pend still set: go to ABRT.
- ABRT: exactly one cycle; dena=1, berr=1; return to RUN. A late ack arriving in ABRT is ignored.
- gpha: toggles on every gclk edge where dena=1 and AEMB_HTX=1; otherwise holds. Reset value 0.
- Interrupt handling:
  - int_pend is set on any cycle with sys_int=1.
  - int_take = dena & int_pend & msr_ie & ~msr_bip & (gpha==0), combinational.
  - int_pend clears on the edge where int_take=1. If sys_int is still high that same cycle, set wins: int_pend stays 1.
  - Thread 1 never takes interrupts.
- Simultaneous events: ABRT and an eligible interrupt in the same cycle give berr=1 and int_take=1 together.
- Every output is driven to a defined value in all states; no X.

Optional Feature:
- Macro: AEMB_BUS_TIMEOUT_EN.
- Defined: timeout counter and ABRT state present, as described in Behaviour.
- Undefined: no counter; WAIT exits only on ~pend; berr tied 0; ABRT unreachable and removed.

Decomposition:
- Shared package aemb2_pkg holds:
  - state encoding typedef tsched_state_t (HOLD=2'd0, RUN=2'd1, WAIT=2'd2, ABRT=2'd3);
  - default constants for AEMB_RSC and AEMB_TOW.
- One sub-module, aemb2_tsched_tmr:
  - loadable/clearable up-counter with terminal-count flag;
  - reused for the HOLD count and, under the macro, the bus timeout.

Test Plan:
1. Reset release: grst 0→1 with all stb=0 → dena=0 for exactly 4 cycles, then 1; gpha then alternates 0,1,0,1.
2. Data stall: dwb_stb=1 for 3 cycles, ack on cycle 3 → dena=0,0,1; gpha frozen during stall, toggles after ack.
3. Interrupt eligibility: sys_int pulse for 1 cycle, msr_ie=1, msr_bip=0 → int_take=1 on the first dena cycle with gpha=0 only, then int_pend=0. Repeat with msr_bip=1 → no int_take until bip drops.
4. Timeout, macro on, AEMB_TOW=4: iwb_stb=1 with no ack → dena=0 for 15 cycles, then one cycle of dena=1 with berr=1, then RUN.
5. Mid-stall reset: grst=0 during WAIT → next cycle state=HOLD, dena=0, gpha=0, int_pend=0.
6. AEMB_HTX=0: 20 free-run cycles → gpha stays 0; int_take may assert on every eligible cycle.

Source files
------------

// File: rtl/aemb2_pkg.sv
// Shared types and default constants for the AEMB2 pipeline sequencer.
package aemb2_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    ABRT = 2'd3
  } tsched_state_t;

  localparam int unsigned AEMB_RSC_DEF = 4;
  localparam int unsigned AEMB_TOW_DEF = 8;
  localparam int unsigned HOLD_W       = 4;

endpackage

// File: rtl/aemb2_tsched_tmr.sv
// Loadable/clearable up-counter; tc flags the all-ones terminal count.
module aemb2_tsched_tmr #(
  parameter int unsigned W = 4
) (
  input  logic         gclk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = ld_val;
    else if (inc)  cnt_d = cnt_q + ONE;
  end

  // Count register.
  always_ff @(posedge gclk) begin
    cnt_q <= cnt_d;
  end

  assign tc = &cnt_q;

endmodule

// File: rtl/aemb2_tsched.sv
// AEMB2 pipeline sequencer / hardware-thread scheduler.
// Optional bus-cycle abort is enabled by defining AEMB_BUS_TIMEOUT_EN.
module aemb2_tsched
  import aemb2_pkg::*;
#(
  parameter int unsigned AEMB_HTX = 1,
  parameter int unsigned AEMB_TOW = AEMB_TOW_DEF,
  parameter int unsigned AEMB_RSC = AEMB_RSC_DEF
) (
  input  logic gclk,
  input  logic grst,
  input  logic iwb_stb,
  input  logic iwb_ack,
  input  logic dwb_stb,
  input  logic dwb_ack,
  input  logic fsl_stb,
  input  logic fsl_ack,
  input  logic sys_int,
  input  logic msr_ie,
  input  logic msr_bip,
  output logic dena,
  output logic gpha,
  output logic int_take,
  output logic berr
);

  localparam logic              HTX_EN  = (AEMB_HTX != 0);
  // Counting up from 16-RSC to all-ones spends exactly RSC cycles in HOLD.
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(16 - AEMB_RSC);

  tsched_state_t state_q, state_d;
  logic          gpha_q, gpha_d;
  logic          int_pend_q, int_pend_d;
  logic          pend;
  logic          hold_done;
  logic          to_done;

  assign pend = (iwb_stb & ~iwb_ack) | (dwb_stb & ~dwb_ack) | (fsl_stb & ~fsl_ack);

  aemb2_tsched_tmr #(.W(HOLD_W)) u_hold (
    .gclk   (gclk),
    .clr    (1'b0),
    .load   (~grst),
    .ld_val (HOLD_LD),
    .inc    (state_q == HOLD),
    .tc     (hold_done)
  );

`ifdef AEMB_BUS_TIMEOUT_EN
  // The first stalled cycle is spent in RUN, so the WAIT phase starts its
  // count at 2; reaching all-ones then marks 2^TOW-1 stalled cycles in total.
  aemb2_tsched_tmr #(.W(AEMB_TOW)) u_tout (
    .gclk   (gclk),
    .clr    (~grst),
    .load   ((state_q == RUN) & pend),
    .ld_val (AEMB_TOW'(2)),
    .inc    ((state_q == WAIT) & pend),
    .tc     (to_done)
  );
`else
  assign to_done = 1'b0;
`endif

  // Sequencer next state and pipeline enable / abort outputs.
  always_comb begin
    state_d = state_q;
    dena    = 1'b0;
    berr    = 1'b0;
    case (state_q)
      HOLD: begin
        if (hold_done) state_d = RUN;
      end
      RUN: begin
        dena = ~pend;
        if (pend) state_d = WAIT;
      end
      WAIT: begin
        dena = ~pend;
        if (!pend)        state_d = RUN;
        else if (to_done) state_d = ABRT;
      end
`ifdef AEMB_BUS_TIMEOUT_EN
      ABRT: begin
        dena    = 1'b1;
        berr    = 1'b1;
        state_d = RUN;
      end
`endif
      default: state_d = HOLD;
    endcase
  end

  // Thread phase, interrupt injection and pending-interrupt latch.
  always_comb begin
    gpha_d     = gpha_q ^ (dena & HTX_EN);
    int_take   = dena & int_pend_q & msr_ie & ~msr_bip & ~gpha_q;
    int_pend_d = sys_int | (int_pend_q & ~int_take);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      state_q    <= HOLD;
      gpha_q     <= 1'b0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gpha_q     <= gpha_d;
      int_pend_q <= int_pend_d;
    end
  end

  assign gpha = gpha_q;

endmodule
